i2c_slave: RTL and testbench

I2C_SLAVE -- requirements
Module: i2c_slave

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_sync_edge.sv | 34 +++
 rtl/i2c_slave.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-slave block.
// No logic; constants and the FSM state encoding only.
// Imported by i2c_slave and its helpers.
package i2c_pkg;

    // Default 7-bit bus address answered by the slave
    localparam logic [6:0] DEF_SLAVE_ADDR = 7'h50;

    // Protocol FSM states
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for a raw bus line plus a history flop for edge detect.
// Latency: lvl/rise/fall reflect the pin 2 clk later, so the FSM acts on the 3rd edge.
// No backpressure; the line is sampled every clk.
module i2c_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    // Resynchronize the line; reset value 1 matches an idle (pulled-up) bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            sync <= 1'b1;
            hist <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
        end
    end

    assign lvl  = sync;
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/i2c_slave.sv
// I2C register slave: pointer byte, then sequential writes or reads with auto-increment.
// Latency: bus events act 3 clk after the pin; wr_stb fires 3 clk after the 8th data SCL rise.
// No local backpressure; rd_dat must be valid within 1 clk of rd_adr changing.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEF_SLAVE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_stb,
    output logic [7:0] wr_adr,
    output logic [7:0] wr_dat,
    output logic [7:0] rd_adr,
    input  logic [7:0] rd_dat,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t     state;
    logic [2:0] bitcnt;
    logic [6:0] shreg;
    logic [6:0] tx;
    logic [7:0] ptr;
    logic       phase;
    logic       rw;
    logic [7:0] rx_byte;

    i2c_sync_edge u_scl (
        .clk  (clk),
        .reset(reset),
        .din  (scl_in),
        .lvl  (scl_lvl),
        .rise (scl_rise),
        .fall (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk  (clk),
        .reset(reset),
        .din  (sda_in),
        .lvl  (sda_lvl),
        .rise (sda_rise),
        .fall (sda_fall)
    );

    // SDA moving while SCL is high marks START / STOP
    assign start_det = scl_lvl & sda_fall;
    assign stop_det  = scl_lvl & sda_rise;

    // Byte including the bit being sampled on this SCL rise, MSB first
    assign rx_byte = {shreg, sda_lvl};
    assign rd_adr  = ptr;

    // Protocol FSM. ACK states use 'phase': first SCL fall drives the ACK,
    // second SCL fall ends it. sda_oe only changes on SCL falls, STOP or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            bitcnt <= 3'd0;
            shreg  <= 7'd0;
            tx     <= 7'd0;
            ptr    <= 8'd0;
            phase  <= 1'b0;
            rw     <= 1'b0;
            sda_oe <= 1'b0;
            wr_stb <= 1'b0;
            wr_adr <= 8'd0;
            wr_dat <= 8'd0;
            busy   <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (start_det) begin
                state  <= ST_ADDR;
                bitcnt <= 3'd0;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: if (scl_rise) begin
                        shreg  <= rx_byte[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state <= ST_ADDR_ACK;
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            phase  <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            phase  <= 1'b0;
                            bitcnt <= 3'd0;
                            if (rw) begin
                                // First read byte is captured here and its MSB driven at once
                                state  <= ST_RDATA;
                                tx     <= rd_dat[6:0];
                                sda_oe <= ~rd_dat[7];
                            end else begin
                                state  <= ST_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shreg  <= rx_byte[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            ptr   <= rx_byte;
                            state <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            phase  <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            phase  <= 1'b0;
                            sda_oe <= 1'b0;
                            bitcnt <= 3'd0;
                            state  <= ST_WDATA;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shreg  <= rx_byte[6:0];
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            wr_stb <= 1'b1;
                            wr_adr <= ptr;
                            wr_dat <= rx_byte;
                            state  <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: if (scl_fall) begin
                        if (!phase) begin
                            phase  <= 1'b1;
                            sda_oe <= 1'b1;
                        end else begin
                            phase  <= 1'b0;
                            sda_oe <= 1'b0;
                            bitcnt <= 3'd0;
                            ptr    <= ptr + 8'd1;
                            state  <= ST_WDATA;
                        end
                    end
                    ST_RDATA: if (scl_fall) begin
                        if (bitcnt == 3'd7) begin
                            // Last bit done; let the master drive its ACK/NACK
                            sda_oe <= 1'b0;
                            phase  <= 1'b0;
                            state  <= ST_RDATA_ACK;
                        end else begin
                            tx     <= {tx[5:0], 1'b0};
                            sda_oe <= ~tx[6];
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                            if (sda_lvl) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                phase <= 1'b1;
                            end
                        end else if (scl_fall && phase) begin
                            // rd_dat already reflects the incremented pointer
                            phase  <= 1'b0;
                            bitcnt <= 3'd0;
                            tx     <= rd_dat[6:0];
                            sda_oe <= ~rd_dat[7];
                            state  <= ST_RDATA;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bus-master tasks, register model, write/read scoreboards.
// Bus bit period is 3*T clk; the slave reacts 3 clk after each pin change.
// The bench master always releases SDA when the slave is expected to drive.
module tb_i2c_slave;

    localparam int T = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       mscl;
    logic       msda;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_stb;
    logic [7:0] wr_adr;
    logic [7:0] wr_dat;
    logic [7:0] rd_adr;
    logic [7:0] rd_dat;
    logic       busy;

    logic [7:0] regs [256];

    int nchk = 0;
    int npass = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int   wr_cnt = 0;
    int   stb_run = 0;
    int   viol = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;
    logic oe_prev = 1'b0;
    logic [15:0] mon_e;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull SDA low
    assign scl_in = mscl;
    assign sda_in = msda & ~sda_oe;
    assign rd_dat = regs[rd_adr];

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk   (clk),
        .reset (reset),
        .scl_in(scl_in),
        .sda_in(sda_in),
        .sda_oe(sda_oe),
        .wr_stb(wr_stb),
        .wr_adr(wr_adr),
        .wr_dat(wr_dat),
        .rd_adr(rd_adr),
        .rd_dat(rd_dat),
        .busy  (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
    endtask

    // Write scoreboard, pulse-width check and bus-discipline monitor
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_run = stb_run + 1;
            check("wr_stb_len", 32'(stb_run), 32'd1);
            if (stb_run == 1) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    check("wr_pending", 32'(exp_wr.size()), 32'd1);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_adr", 32'(wr_adr), 32'(mon_e[15:8]));
                    check("wr_dat", 32'(wr_dat), 32'(mon_e[7:0]));
                end
            end
        end else begin
            stb_run = 0;
        end
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (sda_oe === 1'b1 && !oe_prev && mscl) viol++;
        oe_prev = (sda_oe === 1'b1);
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic b, output logic s);
        msda = b;
        wclk(T);
        mscl = 1'b1;
        wclk(T);
        s = sda_in;
        mscl = 1'b0;
        wclk(T);
    endtask

    task automatic start_c();
        msda = 1'b1;
        wclk(T);
        mscl = 1'b1;
        wclk(T);
        msda = 1'b0;
        wclk(T);
        mscl = 1'b0;
        wclk(T);
    endtask

    task automatic stop_c();
        msda = 1'b0;
        wclk(T);
        mscl = 1'b1;
        wclk(T);
        msda = 1'b1;
        wclk(T);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(~mack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] ev;

        reset = 1'b0;
        mscl  = 1'b1;
        msda  = 1'b1;
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[3] = 8'h11;
        regs[4] = 8'h22;

        // Reset state
        wclk(5);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_adr", 32'(wr_adr), 32'd0);
        check("rst_wr_dat", 32'(wr_dat), 32'd0);
        check("rst_rd_adr", 32'(rd_adr), 32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        reset = 1'b1;
        wclk(10);

        // Write: pointer 0x10, data 0x5A
        start_c();
        wbyte(8'hA0, ack);
        check("w_addr_ack", 32'(ack), 32'd1);
        check("w_busy", 32'(busy), 32'd1);
        wbyte(8'h10, ack);
        check("w_ptr_ack", 32'(ack), 32'd1);
        exp_wr.push_back(16'h105A);
        wbyte(8'h5A, ack);
        check("w_data_ack", 32'(ack), 32'd1);
        stop_c();
        wclk(10);
        check("w_rd_adr", 32'(rd_adr), 32'h11);
        check("w_busy_end", 32'(busy), 32'd0);
        check("w_all_written", 32'(exp_wr.size()), 32'd0);

        // Pointer 0x03, repeated START, read two bytes
        start_c();
        wbyte(8'hA0, ack);
        check("r_addr_ack", 32'(ack), 32'd1);
        wbyte(8'h03, ack);
        check("r_ptr_ack", 32'(ack), 32'd1);
        start_c();
        wbyte(8'hA1, ack);
        check("r_raddr_ack", 32'(ack), 32'd1);
        exp_rd.push_back(8'h11);
        exp_rd.push_back(8'h22);
        rbyte(1'b1, d);
        ev = exp_rd.pop_front();
        check("r_byte0", 32'(d), 32'(ev));
        rbyte(1'b0, d);
        ev = exp_rd.pop_front();
        check("r_byte1", 32'(d), 32'(ev));
        stop_c();
        wclk(10);
        check("r_rd_adr", 32'(rd_adr), 32'h05);
        check("r_busy_end", 32'(busy), 32'd0);

        // Foreign address: no ACK, no drive, never busy
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        start_c();
        wbyte(8'hB0, ack);
        check("na_ack", 32'(ack), 32'd0);
        stop_c();
        wclk(10);
        check("na_oe_seen", 32'(oe_seen), 32'd0);
        check("na_busy_seen", 32'(busy_seen), 32'd0);

        // Pointer wrap 0xFF -> 0x00
        start_c();
        wbyte(8'hA0, ack);
        check("wrap_addr_ack", 32'(ack), 32'd1);
        wbyte(8'hFF, ack);
        check("wrap_ptr_ack", 32'(ack), 32'd1);
        exp_wr.push_back(16'hFF01);
        exp_wr.push_back(16'h0002);
        wbyte(8'h01, ack);
        check("wrap_d0_ack", 32'(ack), 32'd1);
        wbyte(8'h02, ack);
        check("wrap_d1_ack", 32'(ack), 32'd1);
        stop_c();
        wclk(10);
        check("wrap_all_written", 32'(exp_wr.size()), 32'd0);
        check("wrap_rd_adr", 32'(rd_adr), 32'h01);

        // Reset during 4th read bit (regs[1]=0x00 so the slave is pulling low)
        start_c();
        wbyte(8'hA1, ack);
        check("rr_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) bit_x(1'b1, s);
        msda = 1'b1;
        wclk(T);
        mscl = 1'b1;
        wclk(T / 2);
        check("rr_driving", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        check("rr_oe_released", 32'(sda_oe), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_rd_adr", 32'(rd_adr), 32'd0);
        mscl = 1'b0;
        wclk(T);
        reset = 1'b1;
        wclk(T);
        wbyte(8'hA0, ack);
        check("rr_no_start_ignored", 32'(ack), 32'd0);
        stop_c();
        start_c();
        wbyte(8'hA0, ack);
        check("rr_w_addr_ack", 32'(ack), 32'd1);
        wbyte(8'h20, ack);
        check("rr_w_ptr_ack", 32'(ack), 32'd1);
        exp_wr.push_back(16'h2077);
        wbyte(8'h77, ack);
        check("rr_w_data_ack", 32'(ack), 32'd1);
        stop_c();
        wclk(10);
        check("rr_all_written", 32'(exp_wr.size()), 32'd0);
        check("rr_rd_adr_end", 32'(rd_adr), 32'h21);

        // STOP in the middle of a data byte
        start_c();
        wbyte(8'hA0, ack);
        check("ms_addr_ack", 32'(ack), 32'd1);
        wbyte(8'h30, ack);
        check("ms_ptr_ack", 32'(ack), 32'd1);
        bit_x(1'b1, s);
        bit_x(1'b0, s);
        bit_x(1'b1, s);
        check("ms_busy_before", 32'(busy), 32'd1);
        stop_c();
        wclk(4);
        check("ms_sda_oe", 32'(sda_oe), 32'd0);
        check("ms_busy", 32'(busy), 32'd0);
        check("ms_rd_adr", 32'(rd_adr), 32'h30);
        wclk(20);

        // Totals over the whole run
        check("tot_writes", 32'(wr_cnt), 32'd4);
        check("tot_pending", 32'(exp_wr.size()), 32'd0);
        check("tot_drive_scl_high", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
